serial_tx: RTL and testbench
============================

# serial_tx

Word serializer that drives registered state out through output ports. It accepts a WIDTH-bit word on a valid/ready handshake and shifts it onto a single-bit line as a framed serial stream: start bit, data LSB-first, optional parity, stop bit. It sits on the transmit side of the serial link, mirroring the input-latching accumulator blocks. All outputs are register-driven, except `tock_ready`, which is decoded from the state register.

## Interface
Parameters:
- `WIDTH`, 7: data bits per frame (1..16).
- `CLKS_PER_BIT`, 4: clock cycles each line bit is held (≥2).

Ports:
- `clock`  input  1: global clock; all state updates on posedge.
- `reset`  input  1: asynchronous, active-high reset.
- `tock_data`  input  WIDTH: word to send; sampled only on accept.
- `tock_valid`  input  1: producer has a word.
- `tock_ready`  output  1: block can accept; high iff state is IDLE.
- `tx_bit`  output  1: serial line; idles high.
- `tx_busy`  output  1: frame in progress (state ≠ IDLE).
- `sent_count`  output  8: frames completed; wraps modulo 256.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro defined), STOP.
- Accept: when `tock_valid && tock_ready` at a posedge:
  - latch `tock_data` into the shift register;
  - go to START;
  - clear the bit-cycle counter and the bit index.
- Line value by state:
  - START drives 0.
  - DATA drives `shift[0]`.
  - PARITY drives the XOR of all latched bits (even parity).
  - STOP drives 1.
  - IDLE drives 1.
- Bit-cycle counter counts 0..CLKS_PER_BIT-1. On terminal count:
  - START goes to DATA.
  - In DATA, shift right by one and increment the index. After the WIDTH-th bit, go to PARITY or STOP.
  - PARITY goes to STOP.
  - STOP goes to IDLE and increments `sent_count`.
- `tock_data` changes outside an accept are ignored. `tock_valid` dropping mid-frame has no effect.
- `sent_count` wrap: 255 → 0 on the next completed frame, with no flag.
- Reset (asserted at any time, including mid-frame), effective immediately:
  - state goes to IDLE;
  - `tx_bit` = 1, `tx_busy` = 0, `tock_ready` = 1, `sent_count` = 0;
  - shift register, counters and index are cleared.
  - A partially sent frame is abandoned and is not counted.
- Reset deassertion: accept is possible at the first posedge after release.

## Timing
- Accept at edge N:
  - `tx_bit` = 0 and `tx_busy` = 1 from after edge N;
  - `tock_ready` = 0 from after edge N.
- Each line bit is held exactly CLKS_PER_BIT cycles.
- Frame length F = (WIDTH+2)·CLKS_PER_BIT cycles, plus CLKS_PER_BIT with parity.
  - Defaults: F = 36, or 40 with parity.
- STOP exits at edge N+F:
  - `sent_count` increments at that edge;
  - `tock_ready` goes high after it.
- Back-to-back: if `tock_valid` is held, the next accept occurs at edge N+F+1. There is exactly one IDLE cycle (`tx_bit` = 1) between frames, so the minimum stop length is CLKS_PER_BIT+1 cycles.
- No combinational path from `tock_valid`/`tock_data` to any output.

## Configuration
- Macro: `SERIAL_TX_PARITY_EN`.
- Defined:
  - PARITY state is compiled in;
  - one even-parity bit (XOR of data bits) is sent between the last data bit and the stop bit;
  - F grows by CLKS_PER_BIT.
- Undefined:
  - no PARITY state or parity logic;
  - DATA goes directly to STOP.

## Test plan
- Reset idle: assert `reset` mid-cycle, then release.
  - Outputs go to `tx_bit`=1, `tx_busy`=0, `tock_ready`=1, `sent_count`=0 without waiting for a clock edge.
  - They hold for 20 cycles while `tock_valid`=0.
- Single frame, defaults (no parity): accept 7'h55.
  - Line bits, each 4 cycles: 0, 1,0,1,0,1,0,1, 1.
  - `tock_ready` returns 36 cycles after accept; `sent_count`=1.
- Back-to-back: hold `tock_valid` with 7'h7F then 7'h00.
  - Second start bit begins 37 cycles after the first accept.
  - Exactly one idle-high cycle between frames; `sent_count`=2.
- Parity (macro defined):
  - 7'h01 sends parity bit 1; 7'h55 sends parity bit 0.
  - Frame is 40 cycles.
- Reset mid-frame: assert `reset` during data bit 3 of 7'h2A.
  - `tx_bit`=1 immediately and `sent_count` unchanged (0).
  - A new accept after release sends a complete, correct frame.
- Counter wrap: send 256 frames of 7'h33.
  - `sent_count` reads 255 after frame 255 and 0 after frame 256.
  - `tock_data` changes during frames never alter the bits on the line.

Source files
------------

// File: rtl/serial_tx.sv
// Framed word serializer: start bit, WIDTH data bits LSB-first, optional even parity, stop bit.
// Optional parity bit is compiled in with `SERIAL_TX_PARITY_EN`.
module serial_tx #(
  parameter int WIDTH        = 7,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] tock_data,
  input  logic             tock_valid,
  output logic             tock_ready,
  output logic             tx_bit,
  output logic             tx_busy,
  output logic [7:0]       sent_count
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(WIDTH + 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic parity;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_nxt;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic             bit_end;

  assign shift_nxt  = shift >> 1;
  assign bit_end    = (cnt == CW'(CLKS_PER_BIT - 1));
  assign tock_ready = (state == IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift      <= '0;
      cnt        <= '0;
      idx        <= '0;
      tx_bit     <= 1'b1;
      tx_busy    <= 1'b0;
      sent_count <= 8'd0;
`ifdef SERIAL_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      if (state != IDLE)
        cnt <= bit_end ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          if (tock_valid) begin
            shift   <= tock_data;
            cnt     <= '0;
            idx     <= '0;
            state   <= START;
            tx_bit  <= 1'b0;
            tx_busy <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity  <= ^tock_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state  <= DATA;
            tx_bit <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift <= shift_nxt;
            idx   <= idx + 1'b1;
            // line value is loaded one bit ahead so tx_bit stays a plain register
            if (idx == IW'(WIDTH - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
              state  <= PARITY;
              tx_bit <= parity;
`else
              state  <= STOP;
              tx_bit <= 1'b1;
`endif
            end else begin
              tx_bit <= shift_nxt[0];
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state  <= STOP;
            tx_bit <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state      <= IDLE;
            tx_bit     <= 1'b1;
            tx_busy    <= 1'b0;
            sent_count <= sent_count + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          tx_bit  <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: reset, single and back-to-back frames, parity, mid-frame reset, count wrap.
module tb_serial_tx;
  localparam int W   = 7;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NSLOT = W + 3;
  localparam bit PAR   = 1'b1;
`else
  localparam int NSLOT = W + 2;
  localparam bit PAR   = 1'b0;
`endif
  localparam int F = NSLOT * CPB;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] tock_data = '0;
  logic         tock_valid = 1'b0;
  logic         tock_ready;
  logic         tx_bit;
  logic         tx_busy;
  logic [7:0]   sent_count;

  serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clock      (clock),
    .reset      (reset),
    .tock_data  (tock_data),
    .tock_valid (tock_valid),
    .tock_ready (tock_ready),
    .tx_bit     (tx_bit),
    .tx_busy    (tx_busy),
    .sent_count (sent_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_cnt = 8'd0;
  int         t_acc;
  int         t0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected line value k cycles after the accept edge
  function automatic logic exp_bit(input int k, input logic [W-1:0] d, input logic p);
    int s;
    s = k / CPB;
    if (s == 0) return 1'b0;
    if (s <= W) return d[s-1];
    if (PAR && s == W + 1) return p;
    return 1'b1;
  endfunction

  // Start from IDLE at #1 after an edge; accept d at the next edge and check the whole frame.
  task automatic run_frame(input logic [W-1:0] d, input logic p, input logic hold, input logic [W-1:0] next_d);
    tock_data  = d;
    tock_valid = 1'b1;
    @(posedge clock); #1;
    t_acc      = cyc;
    tock_valid = hold;
    tock_data  = next_d;
    for (int k = 0; k < F; k++) begin
      chk("line", tx_bit, exp_bit(k, d, p));
      chk("busy_ready", {tx_busy, tock_ready}, 2'b10);
      if (!hold) tock_data = W'($urandom);
      @(posedge clock); #1;
    end
    exp_cnt++;
    chk("idle_after", {tx_bit, tx_busy, tock_ready}, 3'b101);
    chk("count", sent_count, exp_cnt);
  endtask

  task automatic do_reset();
    #3 reset = 1'b1;
    #1 chk("rst_async", {tx_bit, tx_busy, tock_ready, sent_count}, {3'b101, 8'h00});
    exp_cnt = 8'd0;
    @(posedge clock); @(posedge clock);
    #3 reset = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b1;
    #1 chk("rst_async0", {tx_bit, tx_busy, tock_ready, sent_count}, {3'b101, 8'h00});
    @(posedge clock); @(posedge clock);
    #3 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      chk("idle_hold", {tx_bit, tx_busy, tock_ready, sent_count}, {3'b101, 8'h00});
    end

    // single frame 0x55: line 0,1,0,1,0,1,0,1,(par 0),1
    run_frame(7'h55, 1'b0, 1'b0, 7'h2A);

    // back-to-back with valid held: 0x7F then 0x00
    run_frame(7'h7F, 1'b1, 1'b1, 7'h00);
    t0 = t_acc;
    run_frame(7'h00, 1'b0, 1'b0, 7'h11);
    chk("b2b_gap", 32'(t_acc - t0), 32'(F + 1));

    // parity cases: 0x01 -> 1, 0x55 -> 0
    run_frame(7'h01, 1'b1, 1'b0, 7'h7E);
    run_frame(7'h55, 1'b0, 1'b0, 7'h00);

    // reset during data bit 3 of 0x2A
    tock_data  = 7'h2A;
    tock_valid = 1'b1;
    @(posedge clock); #1;
    tock_valid = 1'b0;
    repeat (17) @(posedge clock);
    #1;
    chk("mid_line", {tx_bit, tx_busy, tock_ready}, 3'b110);
    #3 reset = 1'b1;
    #1 chk("rst_mid", {tx_bit, tx_busy, tock_ready, sent_count}, {3'b101, 8'h00});
    exp_cnt = 8'd0;
    @(posedge clock);
    #3 reset = 1'b0;
    run_frame(7'h2A, 1'b1, 1'b0, 7'h55);
    chk("after_rst_count", sent_count, 8'd1);

    // counter wrap over 256 frames of 0x33
    do_reset();
    for (int i = 0; i < 256; i++) begin
      run_frame(7'h33, 1'b0, 1'b0, W'($urandom));
      if (i == 254) chk("wrap_255", sent_count, 8'd255);
    end
    chk("wrap_0", sent_count, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
